// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared constants, state codes and rotating-priority pick
package mux_rr_arbiter_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  localparam logic [SEL_W-1:0] SEL_A = 2'd0;
  localparam logic [SEL_W-1:0] SEL_B = 2'd1;
  localparam logic [SEL_W-1:0] SEL_C = 2'd2;
  localparam logic [SEL_W-1:0] SEL_D = 2'd3;
  // returns {found, index}; scanning down leaves the entry nearest ptr as winner
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] k;
    rr_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = p + SEL_W'(i);
      if (r[k]) rr_pick = {1'b1, k};
    end
  endfunction
endpackage

// File: rtl/mux.sv
// mux: 4:1 x 4-bit datapath mux selected by S1/S0
module mux (
  input  logic       S1,
  input  logic       S0,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic [3:0] Y
);
  always_comb Y = S1 ? (S0 ? D : C) : (S0 ? B : A);
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst-limited arbiter driving a 4:1 mux with registered output
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [3:0]         A,
  input  logic [3:0]         B,
  input  logic [3:0]         C,
  input  logic [3:0]         D,
  output logic [NUM_REQ-1:0] gnt,
  output logic               S1,
  output logic               S0,
  output logic [3:0]         out_data,
  output logic               out_valid,
  output logic               busy
);
  state_t state, state_n;
  logic [SEL_W-1:0] sel, sel_n, ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [SEL_W:0] pick;
  logic xfer, rel;
  logic [3:0] y;
  mux u_mux (.S1(sel[1]), .S0(sel[0]), .A(A), .B(B), .C(C), .D(D), .Y(y));
  assign S1 = sel[1];
  assign S0 = sel[0];
  assign busy = state == ST_GRANT;
  // release re-arbitrates in the same edge from owner+1, making the old owner lowest priority
  always_comb begin
    xfer = state == ST_GRANT && req[sel];
    rel = state == ST_GRANT && (!req[sel] || (xfer && cnt == CNT_W'(MAX_HOLD - 1)));
    ptr_n = rel ? sel + SEL_W'(1) : ptr;
    pick = rr_pick(req, ptr_n);
    state_n = state;
    gnt_n = gnt;
    sel_n = sel;
    cnt_n = xfer ? cnt + CNT_W'(1) : cnt;
    if (state == ST_IDLE || rel) begin
      state_n = pick[SEL_W] ? ST_GRANT : ST_IDLE;
      gnt_n = pick[SEL_W] ? NUM_REQ'(1) << pick[SEL_W-1:0] : '0;
      sel_n = pick[SEL_W] ? pick[SEL_W-1:0] : sel;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt <= '0;
      sel <= SEL_A;
      ptr <= SEL_A;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      sel <= sel_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      out_valid <= xfer;
      if (xfer) out_data <= y;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed self-checking bench for the round-robin mux arbiter
module tb_mux_rr_arbiter;
  logic clk = 0, rst_n = 0;
  logic [3:0] req = 0, A = 0, B = 0, C = 0, D = 0;
  logic [3:0] gnt, out_data;
  logic S1, S0, out_valid, busy;
  int checks = 0, failures = 0;
  logic [3:0] dat [4];
  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .A(A), .B(B), .C(C), .D(D),
    .gnt(gnt), .S1(S1), .S0(S0), .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n = 0;
    req = r;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst_n = 0;
    req = 4'b0101;
    #2;
    checks++;
    if ({gnt, S1, S0, out_data, out_valid, busy} !== 12'b0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b sel=%b%b data=%b valid=%b busy=%b exp all zero", gnt, S1, S0, out_data, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant got gnt=%b busy=%b exp gnt=0001 busy=1", gnt, busy);
    end
  endtask
  task automatic test_single;
    C = 4'b1111;
    do_reset(4'b0100);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || {S1, S0} !== 2'b10) begin
        failures++;
        $display("FAIL single_gnt k=%0d got gnt=%b sel=%b%b exp gnt=0100 sel=10", k, gnt, S1, S0);
      end
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1111) begin
          failures++;
          $display("FAIL single_data k=%0d got valid=%b data=%b exp valid=1 data=1111", k, out_valid, out_data);
        end
      end
    end
  endtask
  task automatic test_rotation;
    A = 4'b0000; B = 4'b1010; C = 4'b1111; D = 4'b1001;
    dat[0] = A; dat[1] = B; dat[2] = C; dat[3] = D;
    do_reset(4'b1111);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 16) begin
        checks++;
        if (gnt !== 4'b0001 << (((k - 1) / 4) % 4)) begin
          failures++;
          $display("FAIL rotate_gnt k=%0d got gnt=%b exp=%b", k, gnt, 4'b0001 << (((k - 1) / 4) % 4));
        end
      end
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== dat[((k - 2) / 4) % 4]) begin
          failures++;
          $display("FAIL rotate_data k=%0d got valid=%b data=%b exp valid=1 data=%b", k, out_valid, out_data, dat[((k - 2) / 4) % 4]);
        end
      end
    end
  endtask
  task automatic test_early_release;
    int words;
    B = 4'b1010; D = 4'b1001;
    words = 0;
    do_reset(4'b1010);
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL early_first_gnt got gnt=%b exp=0010", gnt);
    end
    tick();
    if (out_valid && out_data == 4'b1010) words++;
    tick();
    if (out_valid && out_data == 4'b1010) words++;
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || out_valid !== 1'b0 || {S1, S0} !== 2'b11) begin
      failures++;
      $display("FAIL early_handover got gnt=%b valid=%b sel=%b%b exp gnt=1000 valid=0 sel=11", gnt, out_valid, S1, S0);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b1001) begin
      failures++;
      $display("FAIL early_next_word got valid=%b data=%b exp valid=1 data=1001", out_valid, out_data);
    end
    checks++;
    if (words != 2) begin
      failures++;
      $display("FAIL early_word_count got=%0d exp=2", words);
    end
  endtask
  task automatic test_reset_mid_burst;
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_pre got gnt=%b exp=1000", gnt);
    end
    rst_n = 0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got gnt=%b valid=%b busy=%b exp 0000 0 0", gnt, out_valid, busy);
    end
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_restart got gnt=%b exp=0001", gnt);
    end
  endtask
  task automatic test_idle_gap;
    D = 4'b1001;
    do_reset(4'b1000);
    tick();
    tick();
    checks++;
    if (gnt !== 4'b1000 || out_valid !== 1'b1 || out_data !== 4'b1001) begin
      failures++;
      $display("FAIL idle_owner got gnt=%b valid=%b data=%b exp 1000 1 1001", gnt, out_valid, out_data);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || {S1, S0} !== 2'b11) begin
      failures++;
      $display("FAIL idle_release got gnt=%b busy=%b sel=%b%b exp 0000 0 11", gnt, busy, S1, S0);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'b1001 || {S1, S0} !== 2'b11 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL idle_hold got valid=%b data=%b sel=%b%b gnt=%b exp 0 1001 11 0000", out_valid, out_data, S1, S0, gnt);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_reset_mid_burst();
    test_idle_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
